// File: rtl/display_scheduler.sv
// Time-multiplexes two score sources and preemptive event values onto a
// saturated 3-digit display, with a common tick prescaler driving dwell times.
module display_scheduler #(
  parameter int PRESCALE     = 50000,
  parameter int ROTATE_TICKS = 1000,
  parameter int HOLD_TICKS   = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] score_a,
  input  logic [11:0] score_b,
  input  logic        evt_req,
  input  logic [11:0] evt_data,
  output logic        evt_ack,
  output logic [11:0] disp_data,
  output logic [1:0]  disp_src,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  localparam int PW = $clog2(PRESCALE + 1);
  localparam int RW = $clog2(ROTATE_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {
    SHOW_A   = 2'd0,
    SHOW_B   = 2'd1,
    SHOW_EVT = 2'd2
  } state_t;

  // Handshake: evt_req is a level held by the requester; it is accepted only
  // in a score state, and evt_ack pulses for one cycle the cycle after the
  // accepting edge, at which point evt_data has been captured.

  state_t        state, state_n, ret, ret_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [RW-1:0] rot, rot_n;
  logic [HW-1:0] hold, hold_n;
  logic [11:0]   latch, latch_n;
  logic          tick, accept;
  logic [11:0]   src_val, sat_val;

  assign tick      = (pcnt == PW'(PRESCALE - 1));
  assign state_dbg = state;

  always_comb begin
    state_n = state;
    ret_n   = ret;
    pcnt_n  = tick ? '0 : pcnt + 1'b1;
    rot_n   = rot;
    hold_n  = hold;
    latch_n = latch;
    accept  = 1'b0;
    case (state)
      SHOW_A, SHOW_B: begin
        // A pending event beats a coinciding rotation tick.
        if (evt_req) begin
          accept  = 1'b1;
          state_n = SHOW_EVT;
          ret_n   = state;
          latch_n = evt_data;
          pcnt_n  = '0;
          hold_n  = '0;
        end else if (tick) begin
          if (rot == RW'(ROTATE_TICKS - 1)) begin
            rot_n   = '0;
            state_n = (state == SHOW_A) ? SHOW_B : SHOW_A;
          end else begin
            rot_n = rot + 1'b1;
          end
        end
      end
      SHOW_EVT: begin
        if (tick) begin
          if (hold == HW'(HOLD_TICKS - 1)) begin
            state_n = ret;
            rot_n   = '0;
            pcnt_n  = '0;
            hold_n  = '0;
          end else begin
            hold_n = hold + 1'b1;
          end
        end
      end
      default: state_n = SHOW_A;
    endcase
  end

  always_comb begin
    case (state)
      SHOW_B:   src_val = score_b;
      SHOW_EVT: src_val = latch;
      default:  src_val = score_a;
    endcase
    sat_val = (src_val > 12'd999) ? 12'd999 : src_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SHOW_A;
      ret       <= SHOW_A;
      pcnt      <= '0;
      rot       <= '0;
      hold      <= '0;
      latch     <= '0;
      evt_ack   <= 1'b0;
      disp_data <= '0;
      disp_src  <= 2'd0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      ret       <= ret_n;
      pcnt      <= pcnt_n;
      rot       <= rot_n;
      hold      <= hold_n;
      latch     <= latch_n;
      evt_ack   <= accept;
      disp_data <= sat_val;
      disp_src  <= state;
      busy      <= (state == SHOW_EVT);
    end
  end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter PRESCALE, default 50000, clk cycles per scheduler tick (>=2).
REQ-002 Parameter ROTATE_TICKS, default 1000, ticks each score source is shown before rotating (>=1).
REQ-003 Parameter HOLD_TICKS, default 2000, ticks an accepted event value is shown (>=1).
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 score_a  input  12  player A value, unsigned binary.
REQ-007 score_b  input  12  player B value, unsigned binary.
REQ-008 evt_req  input  1  event display request; level, held by requester until evt_ack.
REQ-009 evt_data  input  12  event value; valid whenever evt_req=1.
REQ-010 evt_ack  output  1  one-cycle pulse: event accepted and evt_data latched.
REQ-011 disp_data  output  12  value for the 3-digit decimal display, always 0..999.
REQ-012 disp_src  output  2  source currently shown: 0=A, 1=B, 2=event; 3 never driven.
REQ-013 busy  output  1  high while in SHOW_EVT.

Function
REQ-014 Prescaler counts 0..PRESCALE-1 and wraps; internal tick=1 for one cycle when count=PRESCALE-1.
REQ-015 FSM states: SHOW_A, SHOW_B, SHOW_EVT.
REQ-016 Rotation counter increments on tick in SHOW_A/SHOW_B; on tick with count=ROTATE_TICKS-1 it clears and SHOW_A<->SHOW_B toggle.
REQ-017 In SHOW_A/SHOW_B with evt_req=1: next state SHOW_EVT, evt_ack=1 that cycle (registered, visible the following cycle), evt_data latched, return state := current state, prescaler and hold counter cleared.
REQ-018 evt_req coinciding with a rotation tick: event wins; rotation discarded; return state = state before preemption.
REQ-019 SHOW_EVT: hold counter increments on tick; on tick with count=HOLD_TICKS-1 go to return state, rotation counter and prescaler cleared.
REQ-020 evt_req in SHOW_EVT: ignored, no ack, latched value unchanged; if still high on the cycle after return it is accepted per REQ-017.
REQ-021 evt_ack never high on two consecutive cycles; exactly one pulse per accepted event.
REQ-022 disp_data registered every cycle from current state source: SHOW_A->score_a, SHOW_B->score_b, SHOW_EVT->latched evt_data; one-cycle latency after state or input change.
REQ-023 Saturation: source value >999 -> disp_data=999 (e.g. 12'hFFF -> 999); <=999 passed unchanged.
REQ-024 disp_src and busy registered alongside disp_data, same latency.
REQ-025 Dwell per score state = PRESCALE*ROTATE_TICKS cycles; SHOW_EVT dwell = PRESCALE*HOLD_TICKS cycles exactly.

Reset
REQ-026 rst=1 forces immediately: state SHOW_A, all counters 0, return state SHOW_A, latched evt value 0, disp_data 0, disp_src 0, evt_ack 0, busy 0.
REQ-027 rst mid-event: pending hold discarded, no evt_ack emitted after release; operation resumes in SHOW_A with full rotation period.
REQ-028 rst release: first rising edge begins prescaler count 0; no tick before PRESCALE cycles.

Verification (PRESCALE=4, ROTATE_TICKS=3, HOLD_TICKS=2)
REQ-029 Reset release, score_a=123, score_b=456, evt_req=0 -> disp_data=123/src 0 for 12 cycles, then 456/src 1 for 12 cycles, repeating.
REQ-030 evt_req=1, evt_data=77 at cycle 5 in SHOW_A -> one evt_ack pulse, disp_data=77/src 2/busy=1 for 8 cycles, then 123/src 0 with fresh 12-cycle period.
REQ-031 evt_req asserted on the exact rotation tick out of SHOW_B -> event shown 8 cycles, returns to SHOW_B (not SHOW_A).
REQ-032 evt_req held continuously with changing evt_data -> acks spaced by 9 cycles, each event shows value present at its ack.
REQ-033 score_a=1000 and evt_data=4095 -> disp_data=999 in both SHOW_A and SHOW_EVT.
REQ-034 rst pulsed 3 cycles into SHOW_EVT -> outputs 0 during rst; after release SHOW_A, busy=0, no evt_ack until evt_req re-seen.
